traffic_phase_ctrl: RTL and testbench

//  Parametrised successor to the fixed-timing traffic light controller.
//  - Sequences an 8-phase NS/EW cycle with straight and left-turn phases.
//  - Adds a pedestrian green-shortening request and 4 operating modes.
//  - Produces per-direction lamp vectors and BCD countdowns for the segment display driver.
//  - Sits between the board top level and the LED / 7-segment driver modules.

---
 rtl/traffic_phase_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_ctrl
//  Description : 8-phase NS/EW signal sequencer with pedestrian green
//                shortening, four operating modes and BCD countdowns.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int T_G      = 25,
    parameter int T_Y      = 3,
    parameter int T_L      = 15,
    parameter int T_MIN    = 5
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] mode,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       sec_tick,
    output logic [2:0] state,
    output logic [3:0] ns_light,
    output logic [3:0] ew_light,
    output logic [3:0] ns_tens,
    output logic [3:0] ns_ones,
    output logic [3:0] ew_tens,
    output logic [3:0] ew_ones
);

    localparam int              c_PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(TICK_DIV - 1);
    localparam logic [6:0]      c_TG   = 7'(T_G);
    localparam logic [6:0]      c_TY   = 7'(T_Y);
    localparam logic [6:0]      c_TL   = 7'(T_L);
    localparam logic [6:0]      c_TMIN = 7'(T_MIN);

    localparam logic [1:0] c_MODE_NORMAL = 2'b00;
    localparam logic [1:0] c_MODE_FLASH  = 2'b01;
    localparam logic [1:0] c_MODE_RED    = 2'b10;

    // Phase encoding: bit 2 selects the EW half, bits 1:0 the sub-phase
    localparam logic [2:0] c_ST_NS_G  = 3'd0;
    localparam logic [1:0] c_SUB_G    = 2'd0;
    localparam logic [1:0] c_SUB_Y    = 2'd1;
    localparam logic [1:0] c_SUB_L    = 2'd2;

    localparam logic [3:0] c_LAMP_G = 4'b0100;
    localparam logic [3:0] c_LAMP_Y = 4'b0010;
    localparam logic [3:0] c_LAMP_L = 4'b1001;
    localparam logic [3:0] c_LAMP_R = 4'b0001;
    localparam logic [3:0] c_BLANK  = 4'hF;

    logic [c_PW-1:0] r_presc, w_presc_nxt;
    logic [2:0]      r_state, w_state_nxt;
    logic [6:0]      r_remain, w_remain_nxt;
    logic            r_flash, w_flash_nxt;
    logic            r_ped_ack, w_ped_ack_nxt;
    logic [1:0]      r_prev_mode;

    logic            w_tick, w_restart, w_ped_ok;
    logic [c_PW-1:0] w_presc_inc;
    logic [2:0]      w_state_adv;
    logic [3:0]      w_lamp_act;
    logic [6:0]      w_stop_val;
    logic [7:0]      w_bcd_act, w_bcd_stop;

    function automatic logic [6:0] f_dur(input logic [1:0] sub);
        case (sub)
            c_SUB_G: f_dur = c_TG;
            c_SUB_L: f_dur = c_TL;
            default: f_dur = c_TY;
        endcase
    endfunction

    // Time still to run in the active half after the current sub-phase ends
    function automatic logic [6:0] f_rest(input logic [1:0] sub);
        case (sub)
            c_SUB_G: f_rest = c_TY + c_TL + c_TY;
            c_SUB_Y: f_rest = c_TL + c_TY;
            c_SUB_L: f_rest = c_TY;
            default: f_rest = 7'd0;
        endcase
    endfunction

    function automatic logic [7:0] f_bcd(input logic [6:0] v);
        logic [3:0] t;
        logic [6:0] r;
        t = 4'd0;
        r = v;
        for (int k = 0; k < 9; k++) begin
            if (r >= 7'd10) begin
                r = r - 7'd10;
                t = t + 4'd1;
            end
        end
        f_bcd = {t, 4'(r)};
    endfunction

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_presc     <= '0;
            r_state     <= c_ST_NS_G;
            r_remain    <= c_TG;
            r_flash     <= 1'b0;
            r_ped_ack   <= 1'b0;
            r_prev_mode <= c_MODE_NORMAL;
        end else begin
            r_presc     <= w_presc_nxt;
            r_state     <= w_state_nxt;
            r_remain    <= w_remain_nxt;
            r_flash     <= w_flash_nxt;
            r_ped_ack   <= w_ped_ack_nxt;
            r_prev_mode <= mode;
        end
    end

    always_comb begin
        w_tick        = ((mode == c_MODE_NORMAL) || (mode == c_MODE_FLASH)) && (r_presc == c_PMAX);
        w_presc_inc   = w_tick ? '0 : r_presc + c_PW'(1);
        w_state_adv   = r_state + 3'd1;
        w_restart     = (mode == c_MODE_NORMAL) &&
                        ((r_prev_mode == c_MODE_FLASH) || (r_prev_mode == c_MODE_RED));
        w_ped_ok      = (mode == c_MODE_NORMAL) && ped_req && (r_state[1:0] == c_SUB_G) &&
                        (r_remain > c_TMIN) && !w_tick;
        w_presc_nxt   = r_presc;
        w_state_nxt   = r_state;
        w_remain_nxt  = r_remain;
        w_flash_nxt   = r_flash;
        w_ped_ack_nxt = 1'b0;
        if (w_restart) begin
            w_presc_nxt  = '0;
            w_state_nxt  = c_ST_NS_G;
            w_remain_nxt = c_TG;
            w_flash_nxt  = 1'b0;
        end else begin
            case (mode)
                c_MODE_NORMAL: begin
                    w_presc_nxt = w_presc_inc;
                    if (w_tick) begin
                        if (r_remain == 7'd1) begin
                            w_state_nxt  = w_state_adv;
                            w_remain_nxt = f_dur(w_state_adv[1:0]);
                        end else begin
                            w_remain_nxt = r_remain - 7'd1;
                        end
                    end else if (w_ped_ok) begin
                        w_remain_nxt  = c_TMIN;
                        w_ped_ack_nxt = 1'b1;
                    end
                end
                c_MODE_FLASH: begin
                    w_presc_nxt = w_presc_inc;
                    if (w_tick) w_flash_nxt = ~r_flash;
                end
                c_MODE_RED: w_presc_nxt = '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (r_state[1:0])
            c_SUB_G: w_lamp_act = c_LAMP_G;
            c_SUB_L: w_lamp_act = c_LAMP_L;
            default: w_lamp_act = c_LAMP_Y;
        endcase
        w_stop_val = r_remain + f_rest(r_state[1:0]);
        w_bcd_act  = f_bcd(r_remain);
        w_bcd_stop = f_bcd(w_stop_val);

        ns_light = r_state[2] ? c_LAMP_R : w_lamp_act;
        ew_light = r_state[2] ? w_lamp_act : c_LAMP_R;
        {ns_tens, ns_ones} = r_state[2] ? w_bcd_stop : w_bcd_act;
        {ew_tens, ew_ones} = r_state[2] ? w_bcd_act : w_bcd_stop;
        if (mode == c_MODE_FLASH) begin
            ns_light = {2'b00, r_flash, 1'b0};
            ew_light = {2'b00, r_flash, 1'b0};
            ns_tens  = c_BLANK;
            ns_ones  = c_BLANK;
            ew_tens  = c_BLANK;
            ew_ones  = c_BLANK;
        end else if (mode == c_MODE_RED) begin
            ns_light = c_LAMP_R;
            ew_light = c_LAMP_R;
        end
    end

    assign sec_tick = w_tick;
    assign state    = r_state;
    assign ped_ack  = r_ped_ack;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// Bench for traffic_phase_ctrl: directed scenarios plus random modes/requests
// against a table-driven behavioural model compared on every falling edge.
module tb_traffic_phase_ctrl;
    localparam int TD = 4, TG = 5, TY = 2, TL = 3, TMIN = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [1:0] mode;
    logic       ped_req;
    logic       ped_ack, sec_tick;
    logic [2:0] state;
    logic [3:0] ns_light, ew_light, ns_tens, ns_ones, ew_tens, ew_ones;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int m_cnt, m_ph, m_left, m_prev;
    bit m_flash, m_ack;
    int dur[4] = '{TG, TY, TL, TY};
    wire m_tick = (mode < 2'd2) && (m_cnt == TD - 1);

    traffic_phase_ctrl #(.TICK_DIV(TD), .T_G(TG), .T_Y(TY), .T_L(TL), .T_MIN(TMIN)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .mode(mode), .ped_req(ped_req),
        .ped_ack(ped_ack), .sec_tick(sec_tick), .state(state),
        .ns_light(ns_light), .ew_light(ew_light),
        .ns_tens(ns_tens), .ns_ones(ns_ones), .ew_tens(ew_tens), .ew_ones(ew_ones)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rest(input int sub);
        int s = 0;
        for (int k = sub + 1; k < 4; k++) s += dur[k];
        return s;
    endfunction

    function automatic int exp_lamp(input bit ns_dir);
        if (mode == 2'd1) return m_flash ? 2 : 0;
        if (mode == 2'd2) return 1;
        if ((m_ph < 4) != ns_dir) return 1;
        case (m_ph % 4)
            0: return 4;
            2: return 9;
            default: return 2;
        endcase
    endfunction

    function automatic int exp_digit(input bit ns_dir, input bit tens);
        int v;
        if (mode == 2'd1) return 15;
        v = ((m_ph < 4) == ns_dir) ? m_left : m_left + rest(m_ph % 4);
        return tens ? v / 10 : v % 10;
    endfunction

    // Behavioural model: seconds-level phase table walk
    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_cnt <= 0; m_ph <= 0; m_left <= TG; m_flash <= 1'b0; m_ack <= 1'b0; m_prev <= 0;
        end else begin
            m_ack  <= 1'b0;
            m_prev <= int'(mode);
            if (mode == 2'd0 && (m_prev == 1 || m_prev == 2)) begin
                m_ph <= 0; m_left <= TG; m_cnt <= 0; m_flash <= 1'b0;
            end else if (mode == 2'd0) begin
                m_cnt <= (m_cnt + 1) % TD;
                if (m_tick) begin
                    if (m_left == 1) begin
                        m_ph   <= (m_ph + 1) % 8;
                        m_left <= dur[(m_ph + 1) % 4];
                    end else begin
                        m_left <= m_left - 1;
                    end
                end else if (ped_req && (m_ph % 4 == 0) && m_left > TMIN) begin
                    m_left <= TMIN;
                    m_ack  <= 1'b1;
                end
            end else if (mode == 2'd1) begin
                m_cnt <= (m_cnt + 1) % TD;
                if (m_tick) m_flash <= !m_flash;
            end else if (mode == 2'd2) begin
                m_cnt <= 0;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en && !sys_rst) begin
            chk("sec_tick", int'(sec_tick), int'(m_tick));
            chk("state", int'(state), m_ph);
            chk("ped_ack", int'(ped_ack), int'(m_ack));
            chk("ns_light", int'(ns_light), exp_lamp(1'b1));
            chk("ew_light", int'(ew_light), exp_lamp(1'b0));
            chk("ns_tens", int'(ns_tens), exp_digit(1'b1, 1'b1));
            chk("ns_ones", int'(ns_ones), exp_digit(1'b1, 1'b0));
            chk("ew_tens", int'(ew_tens), exp_digit(1'b0, 1'b1));
            chk("ew_ones", int'(ew_ones), exp_digit(1'b0, 1'b0));
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic wait_state(input int tgt);
        int n = 0;
        while (int'(state) != tgt && n < 200) begin
            step();
            n++;
        end
        chk("wait_state", int'(state), tgt);
    endtask

    initial begin
        sys_rst = 1'b1; mode = 2'd0; ped_req = 1'b0;
        repeat (3) step();
        sys_rst = 1'b0;
        chk_en  = 1'b1;
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_ns_digits", int'({ns_tens, ns_ones}), 8'h05);
        chk("rst_ew_digits", int'({ew_tens, ew_ones}), 8'h12);
        chk("rst_ns_light", int'(ns_light), 4'b0100);
        chk("rst_ew_light", int'(ew_light), 4'b0001);
        chk("rst_ped_ack", int'(ped_ack), 0);

        // Full cycle: 20+8+12+8 per half
        repeat (19) step();
        chk("dwell_s0_end", int'(state), 0);
        step();
        chk("dwell_s1", int'(state), 1);
        repeat (76) step();
        chk("cycle96_state", int'(state), 0);
        chk("cycle96_ns_ones", int'(ns_ones), 5);

        // Pedestrian shortening
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("ped_remain", int'(ns_ones), 2);
        chk("ped_ack_hi", int'(ped_ack), 1);
        step();
        chk("ped_ack_lo", int'(ped_ack), 0);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("ped_noack_low_remain", int'(ped_ack), 0);
        repeat (4) step();
        chk("ped_still_s0", int'(state), 0);
        step();
        chk("ped_s1", int'(state), 1);

        // Night flash then return
        mode = 2'd1;
        #1;
        chk("flash_blank_ns", int'(ns_tens), 15);
        chk("flash_blank_ew", int'(ew_ones), 15);
        repeat (20) step();
        mode = 2'd0;
        step();
        chk("flash_exit_state", int'(state), 0);
        chk("flash_exit_ns_ones", int'(ns_ones), 5);
        chk("flash_exit_ns_light", int'(ns_light), 4'b0100);

        // Hold in state 2
        wait_state(2);
        step();
        mode = 2'd3;
        repeat (20) step();
        mode = 2'd0;

        // All-red in state 5
        wait_state(5);
        mode = 2'd2;
        #1;
        chk("red_ns_light", int'(ns_light), 1);
        chk("red_ew_light", int'(ew_light), 1);
        repeat (6) step();
        mode = 2'd0;
        step();
        chk("red_exit_state", int'(state), 0);

        // Asynchronous reset mid state 6
        wait_state(6);
        repeat (3) step();
        #1 sys_rst = 1'b1;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_ns_light", int'(ns_light), 4'b0100);
        chk("async_ew_light", int'(ew_light), 4'b0001);
        step();
        sys_rst = 1'b0;
        repeat (3) step();
        chk("tick_aligned", int'(sec_tick), 1);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("ped_on_tick_noack", int'(ped_ack), 0);
        chk("ped_on_tick_remain", int'(ns_ones), 4);

        // Random operation
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 9))
                    6: mode = 2'd1;
                    7: mode = 2'd2;
                    8, 9: mode = 2'd3;
                    default: mode = 2'd0;
                endcase
            end
            ped_req = ($urandom_range(0, 9) < 2);
            step();
        end
        mode = 2'd0;
        ped_req = 1'b0;
        step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
